// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Contents: arbiter state encoding, memory SIZE encodings, default
// burst/timeout parameters, and a small state-classification helper.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_IBUS = 2'b01,
    ST_DBUS = 2'b10,
    ST_DONE = 2'b11
  } arb_state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int DEF_MAX_DBURST = 4;
  localparam int DEF_TIMEOUT    = 255;

  // True while a transfer owns the memory bus.
  function automatic logic is_bus_state(input arb_state_t s);
    return (s == ST_IBUS) || (s == ST_DBUS);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-cycle timeout counter for the memory arbiter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - restart the count at zero (issued on a bus grant)
//   en        - count one bus cycle
//   expired   - registered flag, high during the LIMIT-th counted cycle
module mem_arb_timer
  import riscv_mem_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_r;
  logic          expired_r;

  // Count bus cycles; the flag is precomputed one cycle early so it is
  // already high during the LIMIT-th bus cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= {CW{1'b0}};
      expired_r <= 1'b0;
    end else if (load) begin
      count_r   <= {CW{1'b0}};
      expired_r <= (LIMIT <= 1);
    end else if (en && !expired_r) begin
      count_r   <= count_r + CW'(1);
      expired_r <= (count_r == CW'(LIMIT - 2));
    end else begin
      count_r   <= count_r;
      expired_r <= expired_r;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack    - fetch requester
//   d_req/d_write/d_size/d_addr/d_wdata -> d_rdata/d_ack - data requester
//   bus_err                          - marks an ack whose transfer timed out
//   MAD/MREQ/WRITE/SIZE/MDT_O        - memory bus outputs (all registered)
//   MDT_I/ACK_n                      - memory read data, active-low ack
// Data normally wins, but after MAX_DBURST consecutive data grants with a
// fetch waiting, the fetch is served next.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DBURST = DEF_MAX_DBURST,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_err,
  output logic [31:0] MAD,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  output logic [31:0] MDT_O,
  input  logic [31:0] MDT_I,
  input  logic        ACK_n
);

  localparam int            DW       = $clog2(MAX_DBURST + 1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(MAX_DBURST);

  arb_state_t    state_r, state_s;
  logic [DW-1:0] dcnt_r, dcnt_s;
  logic          grant_s;
  logic          tmr_en_s;
  logic          tmr_expired_s;

  logic [31:0]   mad_s, mdt_o_s, i_rdata_s, d_rdata_s;
  logic          mreq_s, write_s, i_ack_s, d_ack_s, bus_err_s;
  logic [1:0]    size_s;

  assign tmr_en_s = is_bus_state(state_r);

  mem_arb_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_s),
    .en      (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, burst counter and next values of every registered output.
  // The bus outputs are loaded once at grant and then only held, so the
  // requester inputs cannot disturb a transfer in flight.
  always_comb begin
    state_s   = state_r;
    dcnt_s    = dcnt_r;
    grant_s   = 1'b0;
    mad_s     = MAD;
    mreq_s    = MREQ;
    write_s   = WRITE;
    size_s    = SIZE;
    mdt_o_s   = MDT_O;
    i_ack_s   = 1'b0;
    d_ack_s   = 1'b0;
    bus_err_s = 1'b0;
    i_rdata_s = i_rdata;
    d_rdata_s = d_rdata;

    case (state_r)
      ST_IDLE: begin
        if (d_req && !(i_req && (dcnt_r == DCNT_MAX))) begin
          state_s = ST_DBUS;
          grant_s = 1'b1;
          mreq_s  = 1'b1;
          mad_s   = d_addr;
          write_s = d_write;
          size_s  = d_size;
          mdt_o_s = d_write ? d_wdata : 32'h0000_0000;
          // Only consecutive data grants with a fetch waiting count.
          if (i_req && (dcnt_r != DCNT_MAX)) begin
            dcnt_s = dcnt_r + DW'(1);
          end else if (i_req) begin
            dcnt_s = dcnt_r;
          end else begin
            dcnt_s = {DW{1'b0}};
          end
        end else if (i_req) begin
          state_s = ST_IBUS;
          grant_s = 1'b1;
          mreq_s  = 1'b1;
          mad_s   = i_addr;
          write_s = 1'b0;
          size_s  = SIZE_WORD;
          mdt_o_s = 32'h0000_0000;
          dcnt_s  = {DW{1'b0}};
        end else begin
          mreq_s  = 1'b0;
          mad_s   = 32'h0000_0000;
          write_s = 1'b0;
          size_s  = SIZE_WORD;
          mdt_o_s = 32'h0000_0000;
          dcnt_s  = {DW{1'b0}};
        end
      end

      ST_IBUS, ST_DBUS: begin
        if (!ACK_n || tmr_expired_s) begin
          state_s   = ST_DONE;
          mreq_s    = 1'b0;
          mad_s     = 32'h0000_0000;
          write_s   = 1'b0;
          size_s    = SIZE_WORD;
          mdt_o_s   = 32'h0000_0000;
          i_ack_s   = (state_r == ST_IBUS);
          d_ack_s   = (state_r == ST_DBUS);
          // A real acknowledge in the last allowed cycle still succeeds.
          bus_err_s = ACK_n;
          if (state_r == ST_IBUS) begin
            i_rdata_s = ACK_n ? 32'h0000_0000 : MDT_I;
          end else if (ACK_n) begin
            d_rdata_s = 32'h0000_0000;
          end else if (!WRITE) begin
            d_rdata_s = MDT_I;
          end else begin
            d_rdata_s = d_rdata;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
        mreq_s  = 1'b0;
      end

      default: begin
        state_s = ST_IDLE;
        mreq_s  = 1'b0;
        mad_s   = 32'h0000_0000;
        write_s = 1'b0;
        size_s  = SIZE_WORD;
        mdt_o_s = 32'h0000_0000;
      end
    endcase
  end

  // Burst counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_r  <= {DW{1'b0}};
      MAD     <= 32'h0000_0000;
      MREQ    <= 1'b0;
      WRITE   <= 1'b0;
      SIZE    <= SIZE_WORD;
      MDT_O   <= 32'h0000_0000;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      i_rdata <= 32'h0000_0000;
      d_rdata <= 32'h0000_0000;
    end else begin
      dcnt_r  <= dcnt_s;
      MAD     <= mad_s;
      MREQ    <= mreq_s;
      WRITE   <= write_s;
      SIZE    <= size_s;
      MDT_O   <= mdt_o_s;
      i_ack   <= i_ack_s;
      d_ack   <= d_ack_s;
      bus_err <= bus_err_s;
      i_rdata <= i_rdata_s;
      d_rdata <= d_rdata_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed requests, expected
// transactions queued when driven and checked on the bus and at the ack.
module tb_mem_arbiter;

  localparam int MAXD = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack, bus_err;
  logic [31:0] MAD, MDT_O, MDT_I;
  logic        MREQ, WRITE, ACK_n;
  logic [1:0]  SIZE;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_DBURST (MAXD),
    .TIMEOUT    (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_write (d_write),
    .d_size  (d_size),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .bus_err (bus_err),
    .MAD     (MAD),
    .MREQ    (MREQ),
    .WRITE   (WRITE),
    .SIZE    (SIZE),
    .MDT_O   (MDT_O),
    .MDT_I   (MDT_I),
    .ACK_n   (ACK_n)
  );

  typedef struct {
    bit          is_d;
    bit          wr;
    bit          err;
    bit          chk_rd;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          req_cyc;
    int          lat;
    int          blen;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   ack_delay = 0;
  bit   no_ack    = 1'b0;
  int   wait_cnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory contents model: word at an address is the address plus 3.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h0000_0003;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bus/ack monitor and memory responder.
  always @(negedge clk) begin : mon
    exp_t e;
    check_val("mdt_o_quiet", (MREQ && WRITE) ? 32'h0 : MDT_O, 32'h0);
    if (!i_ack && !d_ack) check_val("bus_err_quiet", {31'h0, bus_err}, 32'h0);
    if (MREQ) begin
      if (exp_q.size() == 0) begin
        check_val("bus_unexp", 32'(exp_q.size()), 32'h1);
      end else begin
        e = exp_q[0];
        check_val("bus_mad", MAD, e.addr);
        check_val("bus_write", {31'h0, WRITE}, {31'h0, e.is_d && e.wr});
        check_val("bus_size", {30'h0, SIZE}, e.is_d ? {30'h0, e.sz} : 32'h0);
        check_val("bus_mdt_o", MDT_O, (e.is_d && e.wr) ? e.wdata : 32'h0);
      end
    end
    if (i_ack || d_ack) begin
      if (exp_q.size() == 0) begin
        check_val("ack_unexp", {30'h0, i_ack, d_ack}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_val("ack_kind", {30'h0, i_ack, d_ack}, e.is_d ? 32'h1 : 32'h2);
        check_val("done_mreq", {31'h0, MREQ}, 32'h0);
        check_val("ack_bus_err", {31'h0, bus_err}, {31'h0, e.err});
        if (e.chk_rd) check_val("ack_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        if (e.lat >= 0) check_val("ack_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
        if (e.blen >= 0) check_val("bus_cycles", 32'(wait_cnt), 32'(e.blen));
      end
    end
    if (MREQ) begin
      ACK_n = (no_ack || (wait_cnt < ack_delay)) ? 1'b1 : 1'b0;
      MDT_I = mem_word(MAD);
      wait_cnt++;
    end else begin
      ACK_n = 1'b1;
      MDT_I = 32'h0;
      wait_cnt = 0;
    end
  end

  task automatic wait_ack(input bit is_d, input string tag);
    bit got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        break;
      end
    end
    check_val({tag, "_ack_seen"}, {31'h0, got}, 32'h1);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_mreq"}, {31'h0, MREQ}, 32'h0);
    check_val({tag, "_write"}, {31'h0, WRITE}, 32'h0);
    check_val({tag, "_size"}, {30'h0, SIZE}, 32'h0);
    check_val({tag, "_mad"}, MAD, 32'h0);
    check_val({tag, "_mdt_o"}, MDT_O, 32'h0);
    check_val({tag, "_i_ack"}, {31'h0, i_ack}, 32'h0);
    check_val({tag, "_d_ack"}, {31'h0, d_ack}, 32'h0);
    check_val({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
    check_val({tag, "_i_rdata"}, i_rdata, 32'h0);
    check_val({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  // One transfer: queue expectation, drive, scramble inputs after grant,
  // wait for the ack, release the request.
  task automatic do_xfer(input bit is_d, input bit wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int dly, input bit nack, input string tag);
    exp_t e;
    @(posedge clk); #1;
    ack_delay = dly;
    no_ack    = nack;
    e.is_d    = is_d;
    e.wr      = wr;
    e.sz      = sz;
    e.addr    = addr;
    e.wdata   = wd;
    e.err     = nack;
    e.chk_rd  = !(is_d && wr) || nack;
    e.rdata   = nack ? 32'h0 : mem_word(addr);
    e.req_cyc = cyc;
    e.lat     = nack ? TMO + 1 : dly + 2;
    e.blen    = nack ? TMO : dly + 1;
    exp_q.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_write = wr; d_size = sz; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(posedge clk); #1;
    if (is_d) begin
      d_addr = ~addr; d_wdata = ~wd; d_write = !wr; d_size = ~sz;
    end else begin
      i_addr = ~addr;
    end
    wait_ack(is_d, tag);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   dk;
    int   ik;
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
    ACK_n = 1'b1; MDT_I = 32'h0;
    repeat (2) @(posedge clk);
    #1 check_zero("rst");
    @(negedge clk) rst = 1'b0;

    do_xfer(1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 0, 1'b0, "fetch");
    do_xfer(1'b1, 1'b1, 2'b00, 32'h8000_0004, 32'hDEAD_BEEF, 0, 1'b0, "store_w");
    do_xfer(1'b1, 1'b0, 2'b10, 32'h0000_4001, 32'h0, 2, 1'b0, "load_b");
    do_xfer(1'b1, 1'b1, 2'b01, 32'h0000_4002, 32'h0000_ABCD, 1, 1'b0, "store_h");

    // Both requesters held: expected grant order D,D,D,D,I twice.
    @(posedge clk); #1;
    ack_delay = 0; no_ack = 1'b0;
    dk = 0; ik = 0;
    for (int s = 0; s < 10; s++) begin
      e.is_d    = ((s % 5) != 4);
      e.wr      = 1'b0;
      e.sz      = 2'b00;
      e.addr    = e.is_d ? 32'h2000 + 32'(4 * dk) : 32'h100 + 32'(4 * ik);
      e.wdata   = 32'h0;
      e.err     = 1'b0;
      e.chk_rd  = 1'b1;
      e.rdata   = mem_word(e.addr);
      e.req_cyc = cyc;
      e.lat     = -1;
      e.blen    = 1;
      if (e.is_d) dk++; else ik++;
      exp_q.push_back(e);
    end
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h2000;
    i_req = 1'b1; i_addr = 32'h100;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          wait_ack(1'b1, "burst_d");
          d_addr = 32'h2000 + 32'(4 * (k + 1));
        end
        d_req = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_ack(1'b0, "burst_i");
          i_addr = 32'h104;
        end
        i_req = 1'b0;
      end
    join

    do_xfer(1'b1, 1'b0, 2'b00, 32'h0000_3000, 32'h0, 0, 1'b1, "timeout");

    // Reset in the middle of a data transfer that is never acknowledged.
    @(posedge clk); #1;
    ack_delay = 0; no_ack = 1'b1;
    e.is_d = 1'b1; e.wr = 1'b0; e.sz = 2'b00; e.addr = 32'h0000_5000;
    e.wdata = 32'h0; e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = 32'h0;
    e.req_cyc = cyc; e.lat = -1; e.blen = -1;
    exp_q.push_back(e);
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0000_5000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_mid_mreq", {31'h0, MREQ}, 32'h1);
    rst = 1'b1;
    d_req = 1'b0;
    #1 check_zero("rst_mid");
    exp_q.delete();
    no_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    do_xfer(1'b1, 1'b0, 2'b00, 32'h0000_6000, 32'h0, 0, 1'b0, "post_rst");

    repeat (4) @(posedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DBURST, default 4: max consecutive data grants while a fetch is pending.
REQ-002 Parameter TIMEOUT, default 255: cycles to wait for ACK_n before aborting a transfer.
REQ-003 clk  in  1  single clock, all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req  in  1  fetch request, held until i_ack.
REQ-006 i_addr  in  32  fetch byte address.
REQ-007 i_rdata  out  32  fetched instruction word.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request, held until d_ack.
REQ-010 d_write  in  1  1=store, 0=load.
REQ-011 d_size  in  2  00 word, 01 half, 10 byte.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data, right-aligned.
REQ-014 d_rdata  out  32  load data, right-aligned, zero-extended by memory.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 bus_err  out  1  qualifies i_ack/d_ack: transfer aborted by timeout.
REQ-017 MAD  out  32  memory address.
REQ-018 MREQ  out  1  memory request.
REQ-019 WRITE  out  1  memory write strobe.
REQ-020 SIZE  out  2  memory access size.
REQ-021 MDT_O  out  32  memory write data.
REQ-022 MDT_I  in  32  memory read data.
REQ-023 ACK_n  in  1  memory acknowledge, active-low.

Function
REQ-024 FSM states: IDLE, IBUS, DBUS, DONE.
REQ-025 IDLE: d_req and not (i_req and dcnt==MAX_DBURST) -> DBUS; else i_req -> IBUS; else stay.
REQ-026 On grant, latch address/size/write/wdata; fetch grant forces WRITE=0, SIZE=00.
REQ-027 In IBUS/DBUS, MREQ=1 and MAD/WRITE/SIZE/MDT_O driven from latched registers only; requester inputs ignored.
REQ-028 ACK_n==0 sampled in IBUS/DBUS -> capture MDT_I into i_rdata/d_rdata (loads and fetches only), go DONE.
REQ-029 DONE: exactly one of i_ack/d_ack high for one cycle, MREQ=0, then IDLE; requests re-evaluated only in IDLE.
REQ-030 Minimum latency, request seen in IDLE to ack: 3 cycles with ACK_n low on first bus cycle.
REQ-031 dcnt increments on each data grant while i_req high, saturates at MAX_DBURST, clears on fetch grant or when i_req low in IDLE.
REQ-032 Simultaneous i_req and d_req with dcnt<MAX_DBURST: data wins.
REQ-033 Bus-cycle counter counts cycles in IBUS/DBUS; reaching TIMEOUT with ACK_n high -> DONE with bus_err=1, rdata=0, MREQ dropped.
REQ-034 bus_err low in all cycles except an aborted DONE.
REQ-035 Store data never presented on MDT_O outside DBUS with WRITE=1; MDT_O=0 otherwise.

Reset
REQ-036 rst high: state IDLE, dcnt=0, bus counter=0, MREQ=WRITE=0, SIZE=00, MAD=MDT_O=0, i_ack=d_ack=bus_err=0, i_rdata=d_rdata=0.
REQ-037 Reset mid-transfer abandons it with no ack; first grant possible in the cycle after rst falls.

Structure
REQ-038 Shared package riscv_mem_pkg holds state encoding, SIZE encodings (WORD/HALF/BYTE) and default MAX_DBURST/TIMEOUT constants.
REQ-039 One sub-module mem_arb_timer: loadable timeout counter with expiry flag; all else in mem_arbiter.

Verification
REQ-040 i_req only, addr 0x0000_0010, ACK_n low first bus cycle, MDT_I=0x0000_0013 -> i_ack pulse 3 cycles after request, i_rdata=0x0000_0013, WRITE=0.
REQ-041 d_req store, addr 0x8000_0004, size 00, wdata 0xDEADBEEF -> MAD=0x8000_0004, WRITE=1, MDT_O=0xDEADBEEF, single d_ack.
REQ-042 i_req and d_req held continuously, MAX_DBURST=4 -> grant order D,D,D,D,I repeating.
REQ-043 d_req load, ACK_n held high, TIMEOUT=8 -> d_ack with bus_err=1 and d_rdata=0 after 8 bus cycles, MREQ low in DONE.
REQ-044 rst asserted during DBUS with ACK_n pending -> all outputs zero within the same cycle, no ack, next request served normally.
